alarm_clock_core: RTL and testbench

//  Parametrised timekeeping core for the alarm-clock family: 24 h HH:MM:SS counter with an internal 1 Hz prescaler.

---
 rtl/alarm_clock_pkg.sv | 25 ++
 rtl/alarm_clock_core_tick_gen.sv | 35 +++
 rtl/alarm_clock_core.sv | 212 +++++++++++++++++++++
 tb/tb_alarm_clock_core.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Package: alarm_clock_pkg
// Shared definitions for the alarm-clock core.
//   state_t  - ring state machine encoding (IDLE, RINGING, SNOOZE)
//   TW       - width of every hour/minute/second field
//   MAX_HR   - last hour value before wrapping to 0
//   MAX_MS   - last minute/second value before wrapping to 0
//   wrap_inc - increment a time field, wrapping to 0 past its maximum
package alarm_clock_pkg;

    localparam int TW = 6;
    localparam logic [TW-1:0] MAX_HR = 6'd23;
    localparam logic [TW-1:0] MAX_MS = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] value,
                                               input logic [TW-1:0] max_value);
        return (value == max_value) ? '0 : value + TW'(1);
    endfunction

endpackage

// File: rtl/alarm_clock_core_tick_gen.sv
// Module: tick_gen
// Divides the system clock down to a one-cycle pulse per second.
//   clk   in  system clock
//   rst   in  synchronous active-low reset
//   clear in  holds the prescaler at 0 and suppresses the pulse
//   tick  out high in the cycle the prescaler sits at CLK_HZ-1
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;

    assign tick = (count == TERM) && !clear;

    // Free-running prescaler; wraps after the terminal count and is parked
    // at zero while the clock is being adjusted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || (count == TERM)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alarm_clock_core.sv
// Module: alarm_clock_core
// 24 h HH:MM:SS timekeeper with NUM_ALARMS armable alarms and a ring FSM.
//   clk, rst (sync active-low)       clocking and reset
//   time_set, mode                   00 adjust clock, 01 adjust alarm[alarm_sel]
//   alarm_sel                        alarm to edit/display (out of range: ignored, shows 0)
//   alarm_arm                        per-alarm arm mask
//   inc_hr, inc_min, stop, snooze    single-cycle strobes
//   outh/outm/outs                   current time
//   alarmh/alarmm                    selected alarm
//   tick_1hz, ringing, ring_id       second pulse, audio trigger, active alarm
// Build option: define ALARM_SNOOZE_EN to build the SNOOZE state and its
// countdown; otherwise the snooze port is accepted and ignored.
module alarm_clock_core
    import alarm_clock_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NUM_ALARMS = 4,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  time_set,
    input  logic [1:0]            mode,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_arm,
    input  logic                  inc_hr,
    input  logic                  inc_min,
    input  logic                  stop,
    input  logic                  snooze,
    output logic [5:0]            outh,
    output logic [5:0]            outm,
    output logic [5:0]            outs,
    output logic [5:0]            alarmh,
    output logic [5:0]            alarmm,
    output logic                  tick_1hz,
    output logic                  ringing,
    output logic [AW-1:0]         ring_id
);

    localparam int RCW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SECS - 1);

    logic          clock_adjust, alarm_adjust, sel_valid;
    logic          tick, tick_d, match_window, match_hit, armed;
    logic [AW-1:0] match_idx, ring_id_next;
    logic [TW-1:0] hr, mn, sc;
    logic [TW-1:0] alarm_hr [NUM_ALARMS];
    logic [TW-1:0] alarm_mn [NUM_ALARMS];
    logic [RCW-1:0] ring_cnt, ring_cnt_next;
    state_t        state, state_next;

`ifdef ALARM_SNOOZE_EN
    localparam int SCW = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [SCW-1:0] SNOOZE_LOAD = SCW'(SNOOZE_MIN * 60);
    logic [SCW-1:0] snooze_cnt, snooze_cnt_next;
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    assign clock_adjust = time_set && (mode == 2'b00);
    assign alarm_adjust = time_set && (mode == 2'b01);
    assign sel_valid    = int'(alarm_sel) < NUM_ALARMS;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (clock_adjust),
        .tick  (tick)
    );

    // Time of day: adjusting parks seconds at zero and wraps fields without
    // carrying; otherwise each tick ripples seconds -> minutes -> hours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hr <= '0;
            mn <= '0;
            sc <= '0;
        end else if (clock_adjust) begin
            sc <= '0;
            if (inc_min) mn <= wrap_inc(mn, MAX_MS);
            if (inc_hr)  hr <= wrap_inc(hr, MAX_HR);
        end else if (tick) begin
            sc <= wrap_inc(sc, MAX_MS);
            if (sc == MAX_MS) begin
                mn <= wrap_inc(mn, MAX_MS);
                if (mn == MAX_MS) hr <= wrap_inc(hr, MAX_HR);
            end
        end
    end

    // Alarm registers; only the selected entry is edited, and only when the
    // selection names a real alarm.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_hr[i] <= '0;
                alarm_mn[i] <= '0;
            end
        end else if (alarm_adjust && sel_valid) begin
            if (inc_hr)  alarm_hr[alarm_sel] <= wrap_inc(alarm_hr[alarm_sel], MAX_HR);
            if (inc_min) alarm_mn[alarm_sel] <= wrap_inc(alarm_mn[alarm_sel], MAX_MS);
        end
    end

    // Remember that the previous edge was a tick so a match is only taken in
    // the single cycle right after the time reaches hh:mm:00.
    always_ff @(posedge clk) begin
        if (!rst) tick_d <= 1'b0;
        else      tick_d <= tick;
    end

    assign match_window = tick_d && (sc == '0) && !clock_adjust;

    // Priority encoder: scan from the top so the lowest matching index wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_arm[i] && (alarm_hr[i] == hr) && (alarm_mn[i] == mn)) begin
                match_hit = 1'b1;
                match_idx = AW'(i);
            end
        end
        match_hit = match_hit && match_window;
    end

    // Ring FSM state and its counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ring_id  <= '0;
            ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt <= '0;
`endif
        end else begin
            state    <= state_next;
            ring_id  <= ring_id_next;
            ring_cnt <= ring_cnt_next;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt <= snooze_cnt_next;
`endif
        end
    end

    assign armed = alarm_arm[ring_id];

    // Next-state logic. stop beats disarm beats snooze beats the ring timer.
    always_comb begin
        state_next    = state;
        ring_id_next  = ring_id;
        ring_cnt_next = ring_cnt;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_next = snooze_cnt;
`endif
        case (state)
            IDLE: begin
                if (match_hit) begin
                    state_next    = RINGING;
                    ring_id_next  = match_idx;
                    ring_cnt_next = '0;
                end
            end
            RINGING: begin
                if (stop || !armed) begin
                    state_next = IDLE;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze) begin
                    state_next      = SNOOZE;
                    snooze_cnt_next = SNOOZE_LOAD;
                end
`endif
                else if (tick) begin
                    if (ring_cnt == RING_LAST) state_next = IDLE;
                    else ring_cnt_next = ring_cnt + RCW'(1);
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (stop || !armed) begin
                    state_next = IDLE;
                end else if (match_hit && (match_idx != ring_id)) begin
                    state_next    = RINGING;
                    ring_id_next  = match_idx;
                    ring_cnt_next = '0;
                end else if (tick) begin
                    if (snooze_cnt == SCW'(1)) begin
                        state_next    = RINGING;
                        ring_cnt_next = '0;
                    end else begin
                        snooze_cnt_next = snooze_cnt - SCW'(1);
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign outh     = hr;
    assign outm     = mn;
    assign outs     = sc;
    assign alarmh   = sel_valid ? alarm_hr[alarm_sel] : '0;
    assign alarmm   = sel_valid ? alarm_mn[alarm_sel] : '0;
    assign tick_1hz = tick;
    assign ringing  = (state == RINGING);

endmodule

// File: tb/tb_alarm_clock_core.sv
// Testbench for alarm_clock_core with CLK_HZ=4, NUM_ALARMS=4, RING_SECS=3,
// SNOOZE_MIN=1. The reference model keeps time as seconds-of-day and alarms
// as minutes-of-day and is advanced once per clock edge.
module tb_alarm_clock_core;

    localparam int CLK_HZ = 4;
    localparam int NA     = 4;
    localparam int RS     = 3;
    localparam int SM     = 1;
    localparam int AW     = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, time_set, inc_hr, inc_min, stop, snooze;
    logic [1:0]    mode;
    logic [AW-1:0] alarm_sel;
    logic [NA-1:0] alarm_arm;
    logic [5:0]    outh, outm, outs, alarmh, alarmm;
    logic          tick_1hz, ringing;
    logic [AW-1:0] ring_id;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_sec, m_pre, m_id, m_left, m_sleft;
    int m_al [NA];
    bit m_ring, m_snz, m_jt;

    always #5 clk = ~clk;

    alarm_clock_core #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
        .clk(clk), .rst(rst), .time_set(time_set), .mode(mode), .alarm_sel(alarm_sel),
        .alarm_arm(alarm_arm), .inc_hr(inc_hr), .inc_min(inc_min), .stop(stop), .snooze(snooze),
        .outh(outh), .outm(outm), .outs(outs), .alarmh(alarmh), .alarmm(alarmm),
        .tick_1hz(tick_1hz), .ringing(ringing), .ring_id(ring_id)
    );

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        bit adj, tk, hit;
        int idx, h, mi;
        if (!rst) begin
            m_sec = 0; m_pre = 0; m_ring = 0; m_snz = 0; m_id = 0; m_jt = 0;
            foreach (m_al[i]) m_al[i] = 0;
            return;
        end
        adj = time_set && (mode == 2'b00);
        tk  = !adj && (m_pre == CLK_HZ - 1);
        hit = 0; idx = 0;
        if (m_jt && (m_sec % 60 == 0) && !adj)
            for (int i = NA - 1; i >= 0; i--)
                if (alarm_arm[i] && m_al[i] == m_sec / 60) begin hit = 1; idx = i; end
        if (m_ring) begin
            if (stop || !alarm_arm[m_id]) m_ring = 0;
            else if (SNZ && snooze) begin m_ring = 0; m_snz = 1; m_sleft = SM * 60; end
            else if (tk) begin m_left--; if (m_left == 0) m_ring = 0; end
        end else if (m_snz) begin
            if (stop || !alarm_arm[m_id]) m_snz = 0;
            else if (hit && idx != m_id) begin m_snz = 0; m_ring = 1; m_id = idx; m_left = RS; end
            else if (tk) begin
                m_sleft--;
                if (m_sleft == 0) begin m_snz = 0; m_ring = 1; m_left = RS; end
            end
        end else if (hit) begin
            m_ring = 1; m_id = idx; m_left = RS;
        end
        if (time_set && mode == 2'b01 && int'(alarm_sel) < NA) begin
            h  = m_al[alarm_sel] / 60;
            mi = m_al[alarm_sel] % 60;
            if (inc_hr)  h  = (h + 1) % 24;
            if (inc_min) mi = (mi + 1) % 60;
            m_al[alarm_sel] = h * 60 + mi;
        end
        if (adj) begin
            h  = m_sec / 3600;
            mi = (m_sec / 60) % 60;
            if (inc_hr)  h  = (h + 1) % 24;
            if (inc_min) mi = (mi + 1) % 60;
            m_sec = h * 3600 + mi * 60;
            m_pre = 0;
        end else if (tk) begin
            m_sec = (m_sec + 1) % 86400;
            m_pre = 0;
        end else begin
            m_pre++;
        end
        m_jt = tk;
    endtask

    function automatic logic [33:0] model_vec();
        bit tk;
        int a;
        tk = !(time_set && mode == 2'b00) && (m_pre == CLK_HZ - 1);
        a  = (int'(alarm_sel) < NA) ? m_al[alarm_sel] : 0;
        return {6'(m_sec / 3600), 6'((m_sec / 60) % 60), 6'(m_sec % 60),
                6'(a / 60), 6'(a % 60), tk, m_ring, AW'(m_id)};
    endfunction

    function automatic logic [33:0] dut_vec();
        return {outh, outm, outs, alarmh, alarmm, tick_1hz, ringing, ring_id};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulse(input bit hr, input bit mn);
        inc_hr = hr; inc_min = mn;
        cycle();
        inc_hr = 0; inc_min = 0;
    endtask

    task automatic do_reset();
        rst = 0; time_set = 0; mode = 2'b11; alarm_sel = '0; alarm_arm = '0;
        inc_hr = 0; inc_min = 0; stop = 0; snooze = 0;
        cycle();
        rst = 1;
    endtask

    task automatic set_time(input int hh, input int mm);
        time_set = 1; mode = 2'b00;
        cycle();
        repeat (hh) pulse(1, 0);
        repeat (mm) pulse(0, 1);
        time_set = 0; mode = 2'b11;
    endtask

    task automatic set_alarm(input int idx, input int hh, input int mm);
        time_set = 1; mode = 2'b01; alarm_sel = AW'(idx);
        repeat (hh) pulse(1, 0);
        repeat (mm) pulse(0, 1);
        time_set = 0; mode = 2'b11;
    endtask

    task automatic run_until_sec(input int target, input int bound, output bit ok);
        ok = 0;
        for (int n = 0; n < bound; n++) begin
            if (m_sec == target) begin ok = 1; break; end
            cycle();
        end
    endtask

    task automatic wait_ring(input int bound, output bit ok);
        ok = 0;
        for (int n = 0; n < bound; n++) begin
            cycle();
            if (ringing === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        int ticks;
        rst = 0; time_set = 0; mode = 2'b11; alarm_sel = '0; alarm_arm = '1;
        inc_hr = 0; inc_min = 0; stop = 0; snooze = 0;
        cycle(); cycle();
        total++;
        if (dut_vec() !== 34'd0) begin
            bad++; $display("[TB] FAIL reset_outputs: got %h expected %h", dut_vec(), 34'd0);
        end
        rst = 1;
        ticks = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (tick_1hz === 1'b1) ticks++;
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("[TB] FAIL reset_run: got %h expected %h", dut_vec(), model_vec());
            end
        end
        total++;
        if (ticks != 3 || outs !== 6'd3) begin
            bad++; $display("[TB] FAIL tick_rate: got ticks=%0d s=%0d expected ticks=3 s=3", ticks, outs);
        end
    endtask

    task automatic test_tick();
        bit ok;
        do_reset();
        set_time(23, 59);
        run_until_sec(86399, 400, ok);
        total++;
        if (!ok || {outh, outm, outs} !== {6'd23, 6'd59, 6'd59}) begin
            bad++; $display("[TB] FAIL tick_235959: got %0d:%0d:%0d expected 23:59:59", outh, outm, outs);
        end
        run_until_sec(0, 8, ok);
        total++;
        if (!ok || {outh, outm, outs} !== 18'd0) begin
            bad++; $display("[TB] FAIL tick_midnight: got %0d:%0d:%0d expected 0:0:0", outh, outm, outs);
        end
    endtask

    task automatic test_adjust();
        bit ok;
        do_reset();
        set_time(10, 59);
        run_until_sec(10 * 3600 + 59 * 60 + 30, 200, ok);
        time_set = 1; mode = 2'b00;
        pulse(0, 1);
        total++;
        if (!ok || {outh, outm, outs} !== {6'd10, 6'd0, 6'd0}) begin
            bad++; $display("[TB] FAIL adj_min_wrap: got %0d:%0d:%0d expected 10:0:0", outh, outm, outs);
        end
        repeat (13) pulse(1, 0);
        total++;
        if (outh !== 6'd23) begin
            bad++; $display("[TB] FAIL adj_hr_23: got %0d expected 23", outh);
        end
        for (int n = 0; n < 6; n++) begin
            cycle();
            total++;
            if (outs !== 6'd0 || tick_1hz !== 1'b0) begin
                bad++; $display("[TB] FAIL adj_hold: got s=%0d tick=%b expected s=0 tick=0", outs, tick_1hz);
            end
        end
        pulse(1, 0);
        total++;
        if (outh !== 6'd0) begin
            bad++; $display("[TB] FAIL adj_hr_wrap: got %0d expected 0", outh);
        end
        pulse(1, 1);
        total++;
        if ({outh, outm} !== {6'd1, 6'd1} || dut_vec() !== model_vec()) begin
            bad++; $display("[TB] FAIL adj_both: got %h expected %h", dut_vec(), model_vec());
        end
        time_set = 0; mode = 2'b11;
    endtask

    task automatic test_ring();
        int t0, t1, ticks;
        do_reset();
        set_alarm(2, 0, 1);
        alarm_arm = 4'b0100;
        t0 = -1; t1 = -1;
        for (int n = 0; n < 400; n++) begin
            cycle();
            if (t0 < 0 && outm == 6'd1 && outs == 6'd0) t0 = n;
            if (ringing === 1'b1) begin t1 = n; break; end
        end
        total++;
        if (t1 < 0 || t1 - t0 != 1 || ring_id !== 2'd2) begin
            bad++; $display("[TB] FAIL ring_rise: got latency=%0d id=%0d expected latency=1 id=2", t1 - t0, ring_id);
        end
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++; $display("[TB] FAIL ring_state: got %h expected %h", dut_vec(), model_vec());
        end
        ticks = 0;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (ringing !== 1'b1) break;
            if (tick_1hz === 1'b1) ticks++;
        end
        total++;
        if (ringing !== 1'b0 || ticks != RS) begin
            bad++; $display("[TB] FAIL ring_auto_dismiss: got ringing=%b ticks=%0d expected ringing=0 ticks=%0d", ringing, ticks, RS);
        end
    endtask

    task automatic test_priority();
        bit ok;
        do_reset();
        set_alarm(0, 0, 1); set_alarm(3, 0, 1);
        alarm_arm = 4'b1001;
        wait_ring(400, ok);
        total++;
        if (!ok || ring_id !== 2'd0) begin
            bad++; $display("[TB] FAIL prio_id: got ok=%b id=%0d expected ok=1 id=0", ok, ring_id);
        end
        stop = 1; cycle(); stop = 0;
        total++;
        if (ringing !== 1'b0 || dut_vec() !== model_vec()) begin
            bad++; $display("[TB] FAIL prio_stop: got %h expected %h", dut_vec(), model_vec());
        end
        do_reset();
        set_alarm(0, 0, 1); set_alarm(3, 0, 1);
        alarm_arm = 4'b1001;
        wait_ring(400, ok);
        alarm_arm = 4'b1000;
        cycle();
        total++;
        if (!ok || ringing !== 1'b0) begin
            bad++; $display("[TB] FAIL prio_disarm: got ok=%b ringing=%b expected ok=1 ringing=0", ok, ringing);
        end
        for (int n = 0; n < 8; n++) begin
            cycle();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("[TB] FAIL prio_after: got %h expected %h", dut_vec(), model_vec());
            end
        end
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        bit ok;
        int ticks;
        do_reset();
        set_alarm(1, 0, 1);
        alarm_arm = 4'b0010;
        wait_ring(400, ok);
        snooze = 1; cycle(); snooze = 0;
        total++;
        if (!ok || ringing !== 1'b0) begin
            bad++; $display("[TB] FAIL snooze_enter: got ok=%b ringing=%b expected ok=1 ringing=0", ok, ringing);
        end
        ticks = (tick_1hz === 1'b1) ? 1 : 0;
        for (int n = 0; n < 400; n++) begin
            cycle();
            if (ringing === 1'b1) break;
            if (tick_1hz === 1'b1) ticks++;
        end
        total++;
        if (ringing !== 1'b1 || ticks != SM * 60 || ring_id !== 2'd1) begin
            bad++; $display("[TB] FAIL snooze_expire: got ringing=%b ticks=%0d id=%0d expected ringing=1 ticks=%0d id=1", ringing, ticks, ring_id, SM * 60);
        end
        stop = 1; snooze = 1; cycle(); stop = 0; snooze = 0;
        total++;
        if (ringing !== 1'b0 || dut_vec() !== model_vec()) begin
            bad++; $display("[TB] FAIL snooze_stop_wins: got %h expected %h", dut_vec(), model_vec());
        end
    endtask
`else
    task automatic test_snooze();
        bit ok;
        int ticks;
        do_reset();
        set_alarm(1, 0, 1);
        alarm_arm = 4'b0010;
        wait_ring(400, ok);
        ticks = 0;
        snooze = 1; cycle(); snooze = 0;
        total++;
        if (!ok || ringing !== 1'b1) begin
            bad++; $display("[TB] FAIL snooze_ignored: got ok=%b ringing=%b expected ok=1 ringing=1", ok, ringing);
        end
        if (tick_1hz === 1'b1) ticks++;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (ringing !== 1'b1) break;
            if (tick_1hz === 1'b1) ticks++;
        end
        total++;
        if (ringing !== 1'b0 || ticks != RS) begin
            bad++; $display("[TB] FAIL snooze_off_dismiss: got ringing=%b ticks=%0d expected ringing=0 ticks=%0d", ringing, ticks, RS);
        end
    endtask
`endif

    task automatic test_reset_mid_ring();
        bit ok;
        do_reset();
        set_alarm(0, 0, 1);
        alarm_arm = 4'b0001;
        wait_ring(400, ok);
        rst = 0; cycle();
        total++;
        if (!ok || dut_vec() !== 34'd0) begin
            bad++; $display("[TB] FAIL reset_mid_ring: got ok=%b out=%h expected ok=1 out=0", ok, dut_vec());
        end
        rst = 1;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < NA; i++) set_alarm(i, 0, 1 + $urandom_range(0, 2));
        alarm_arm = NA'($urandom_range(1, 15));
        for (int n = 0; n < 1200 && bad < 30; n++) begin
            stop   = ($urandom_range(0, 39) == 0);
            snooze = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) alarm_arm = alarm_arm ^ NA'(1 << $urandom_range(0, NA - 1));
            alarm_sel = AW'($urandom_range(0, NA - 1));
            r = $urandom_range(0, 199);
            time_set = (r < 3);
            mode     = (r == 0) ? 2'b00 : ((r < 3) ? 2'b01 : 2'b11);
            inc_min  = (r < 3) && ($urandom_range(0, 1) == 1);
            inc_hr   = 1'b0;
            cycle();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("[TB] FAIL random_cycle%0d: got %h expected %h", n, dut_vec(), model_vec());
            end
        end
        stop = 0; snooze = 0; time_set = 0; inc_min = 0; mode = 2'b11;
    endtask

    initial begin
        m_sec = 0; m_pre = 0; m_id = 0; m_left = 0; m_sleft = 0;
        m_ring = 0; m_snz = 0; m_jt = 0;
        foreach (m_al[i]) m_al[i] = 0;
        test_reset();
        test_tick();
        test_adjust();
        test_ring();
        test_priority();
        test_snooze();
        test_reset_mid_ring();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
